// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the controller and target ends of the bus.
`timescale 1ns/1ps
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge, START and STOP detection (one-clk pulses).
`timescale 1ns/1ps
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_p,
  output logic stop_p
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;

  // Flops reset to 1 (idle bus level) so leaving reset never fakes an edge on an idle bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise =  scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s &  scl_hist_q;
  assign start_p  =  scl_s &  scl_hist_q &  sda_hist_q & ~sda_s;
  assign stop_p   =  scl_s &  scl_hist_q & ~sda_hist_q &  sda_s;

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target: address match, write receive, read serve; open-drain SDA.
`timescale 1ns/1ps
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  input  logic                  rx_nack,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_req,
  output logic                  rw,
  output logic                  busy,
  output logic                  stop_det,
  output logic [2:0]            dbg_state
);

  localparam logic [3:0] BIT_LAST = 4'd7;
  localparam logic [3:0] BIT_DONE = 4'd8;

  logic sda_s, scl_rise, scl_fall, start_p, stop_p;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_p  (start_p),
    .stop_p   (stop_p)
  );

  i2c_state_e            state_q;
  logic [3:0]            bit_cnt_q;
  logic [I2C_BYTE_W-2:0] shift_q;   // low 7 bits; the 8th is taken live from sda_s or driven directly
  logic                  sda_oe_q;
  logic                  ack_ok_q;
  logic                  load_q;
  logic [I2C_BYTE_W-1:0] rx_data_q;
  logic                  rx_valid_q, tx_req_q, rw_q, busy_q, stop_det_q;

  // Read handshake: tx_req pulses for one clk; tx_data is captured at the clock edge that
  // ends that pulse, so the host must present the byte while tx_req is high. No back-pressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sda_oe_q   <= 1'b0;
      ack_ok_q   <= 1'b0;
      load_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      stop_det_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      stop_det_q <= 1'b0;
      if (stop_p) begin
        sda_oe_q   <= 1'b0;
        load_q     <= 1'b0;
        busy_q     <= 1'b0;
        stop_det_q <= 1'b1;
        state_q    <= IDLE;
      end else if (start_p) begin
        sda_oe_q  <= 1'b0;
        load_q    <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt_q <= '0;
        shift_q   <= '0;
        state_q   <= ADDR;
      end else begin
        if (load_q) begin
          shift_q  <= tx_data[I2C_BYTE_W-2:0];
          sda_oe_q <= ~tx_data[I2C_BYTE_W-1];
          load_q   <= 1'b0;
        end
        case (state_q)
          IDLE: ;
          ADDR: begin
            if (scl_rise && bit_cnt_q < BIT_DONE) begin
              shift_q   <= {shift_q[I2C_BYTE_W-3:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == BIT_LAST) begin
                if (shift_q == TARGET_ADDR) begin
                  rw_q   <= sda_s;
                  busy_q <= 1'b1;
                end else begin
                  state_q <= IDLE;
                end
              end
            end else if (scl_fall && bit_cnt_q == BIT_DONE) begin
              sda_oe_q <= 1'b1;
              state_q  <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              if (rw_q) begin
                tx_req_q <= 1'b1;
                load_q   <= 1'b1;
                state_q  <= RD_DATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise && bit_cnt_q < BIT_DONE) begin
              shift_q   <= {shift_q[I2C_BYTE_W-3:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == BIT_LAST) begin
                rx_data_q  <= {shift_q, sda_s};
                rx_valid_q <= 1'b1;
              end
            end else if (scl_fall && bit_cnt_q == BIT_DONE) begin
              sda_oe_q  <= ~rx_nack;
              ack_ok_q  <= ~rx_nack;
              bit_cnt_q <= '0;
              state_q   <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              if (ack_ok_q) begin
                state_q <= WR_DATA;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == BIT_LAST) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= RD_ACK;
              end else begin
                sda_oe_q  <= ~shift_q[I2C_BYTE_W-2];
                shift_q   <= {shift_q[I2C_BYTE_W-3:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              ack_ok_q <= ~sda_s;
            end else if (scl_fall) begin
              if (ack_ok_q) begin
                tx_req_q <= 1'b1;
                load_q   <= 1'b1;
                state_q  <= RD_DATA;
              end else begin
                // busy stays set until the controller closes the transfer
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign rw        = rw_q;
  assign busy      = busy_q;
  assign stop_det  = stop_det_q;
  assign dbg_state = state_q;

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Single-address I2C target (responder), the far end of the team's I2C controller on the same SCL/SDA bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address and ACKs it, then either receives write bytes for the host logic or serves read bytes supplied by the host logic.
- Drives SDA open-drain: low or released, never high.

Parameters:
TARGET_ADDR, 7'h50, 7-bit bus address this target answers to
SYNC_STAGES, 2, synchronizer flops on scl/sda inputs (legal: 2..3)

Ports:
clk  input  1  system clock (100 MHz nominal; at least 8x SCL)
rst  input  1  asynchronous active-low reset
scl  input  1  bus clock from controller
sda  inout  1  bus data; driven 1'b0 or 1'bz only
tx_data  input  8  byte to return on a read; sampled when tx_req pulses
rx_nack  input  1  when 1, the current write byte is NACKed
rx_data  output  8  last received write byte
rx_valid  output  1  1-clk pulse when rx_data updates
tx_req  output  1  1-clk pulse requesting the next read byte
rw  output  1  R/W bit of the current transfer (1 = read)
busy  output  1  high from address match until STOP or START
stop_det  output  1  1-clk pulse on any STOP condition

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE, SDA released.
  - rx_data=0, rx_valid=0, tx_req=0, rw=0, busy=0, stop_det=0.
  - bit counter=0, shift regs=0.
- Input conditioning:
  - scl/sda pass through SYNC_STAGES flops, plus one history flop each.
  - Edges are decided on the synchronized values: scl_rise, scl_fall, sda_rise, sda_fall.
- Bus conditions (SCL synchronized high):
  - sda_fall = START. sda_rise = STOP.
  - Both take priority over the FSM in any state, including mid-byte.
  - On START: release SDA, clear bit count, go to ADDR, busy=0.
  - On STOP: release SDA, go to IDLE, busy=0, pulse stop_det.
- Bit timing:
  - Sample SDA on scl_rise.
  - Change the SDA drive on scl_fall only. The drive is registered, so it updates 1 clk after scl_fall is detected.
  - Bytes are MSB first; the R/W bit is the 8th address bit.
- FSM transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - On the 8th scl_rise, compare [7:1] with TARGET_ADDR.
    - Match: latch rw, busy=1. On the next scl_fall drive SDA low, go to ADDR_ACK.
    - Mismatch: go to IDLE and ignore the bus until the next START.
  - ADDR_ACK: SDA held low through the ACK clock.
    - On the ACK scl_fall, rw=0: release SDA, go to WR_DATA.
    - On the ACK scl_fall, rw=1: pulse tx_req, load tx_data into the shift register on the following clk, drive its MSB, go to RD_DATA.
  - WR_DATA: shift 8 bits.
    - On the 8th scl_rise, rx_data <= shifted byte and rx_valid pulses once.
    - On the next scl_fall: drive SDA low unless rx_nack=1 (sampled at that scl_fall). Go to WR_ACK.
  - WR_ACK: on scl_fall, release SDA.
    - Had ACKed: go to WR_DATA.
    - Had NACKed: go to IDLE, busy=0.
  - RD_DATA: on each scl_fall shift out the next bit (0 bit -> drive low, 1 bit -> release).
    - After the 8th bit's scl_fall, release SDA and go to RD_ACK.
  - RD_ACK: sample the controller's ACK on scl_rise.
    - SDA=0 (ACK): on scl_fall pulse tx_req, load, drive MSB, go to RD_DATA.
    - SDA=1 (NACK): go to IDLE and keep SDA released until STOP/START. busy stays 1 until that STOP/START.
- tx_data must be valid on the clk tx_req is high; it is sampled there.
- Mid-operation reset: SDA released immediately (asynchronously); no partial rx_valid is issued.
- rx_nack is ignored outside the write-ACK slot.
- Clock stretching is not supported; SCL is input only.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding constants (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK);
  - I2C_ADDR_W=7 and I2C_BYTE_W=8, used by both controller and target.
- Sub-module i2c_bus_sync: synchronizers plus edge/START/STOP detection, outputs one-clk pulses. The FSM stays in i2c_target.

Test Plan:
- Write, address match: START, 0xA0 (0x50, W), byte 0x3C, STOP.
  - Required: target pulls SDA low in both ACK slots.
  - Required: rx_data=0x3C with one rx_valid pulse; stop_det pulses; busy returns to 0.
- Address mismatch: START, 0xA2, byte 0xFF.
  - Required: SDA never driven low by the target; no rx_valid; busy=0 throughout.
- Read, two bytes: START, 0xA1, tx_data=0x96 then 0x5A, controller ACKs byte 1 and NACKs byte 2, STOP.
  - Required: bus carries 0x96, 0x5A MSB first; exactly 2 tx_req pulses; SDA released after the NACK.
- Write NACK: rx_nack=1 while receiving 0x11.
  - Required: rx_data=0x11 and rx_valid pulses; the ACK slot sees SDA=1; FSM in IDLE.
- Repeated START: 0xA0, 0x01, then repeated START, 0xA1, read 1 byte, NACK, STOP.
  - Required: rw switches 0 -> 1; tx_req pulses once; no stop_det before the final STOP.
- Async reset mid-byte: assert rst during the 4th bit of a read byte 0x00.
  - Required: SDA released within the same clk; all outputs at reset values; the next START+0xA0 is ACKed normally.
